// File: rtl/psram_pkg.sv
// Shared types and constants for the QSPI PSRAM controller.
package psram_pkg;

  localparam int ADDR_W = 24;
  localparam int DATA_W = 32;

  localparam logic [7:0] PSRAM_CMD_QWRITE = 8'h38;
  localparam logic [7:0] PSRAM_CMD_QREAD  = 8'hEB;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    WDATA,
    DUMMY,
    RDATA,
    RESP,
    GAP
  } state_e;

  typedef enum logic [2:0] {
    SH_HOLD,
    SH_LOAD,
    SH_BIT,
    SH_NIB_OUT,
    SH_NIB_IN
  } sh_op_e;

  function automatic logic [2:0] norm_bytes(input logic [2:0] b);
    return (b == 3'd0 || b > 3'd4) ? 3'd4 : b;
  endfunction

  function automatic logic [31:0] bswap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/psram_ctrl_if.sv
// Request/response bundle between the bus bridge and the PSRAM controller.
interface psram_ctrl_if;
  import psram_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [2:0]        req_bytes;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_write, req_addr,
    output req_bytes, req_wdata, resp_ready,
    input  req_ready, resp_valid,
    input  resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr,
    input  req_bytes, req_wdata, resp_ready,
    output req_ready, resp_valid,
    output resp_rdata, resp_err
  );
endinterface

// File: rtl/psram_ctrl_shifter.sv
// 32-bit bit/nibble shift register plus the per-state sck cycle counter.
module psram_ctrl_shifter
  import psram_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  sh_op_e      op,
  input  logic [31:0] load_val,
  input  logic [3:0]  din,
  input  logic        tick,
  input  logic        clr,
  output logic [31:0] sr,
  output logic [3:0]  cnt
);

  logic [31:0] sr_q, sr_d;
  logic [3:0]  cnt_q, cnt_d;

  always_comb begin
    sr_d = sr_q;
    case (op)
      SH_LOAD:    sr_d = load_val;
      SH_BIT:     sr_d = {sr_q[30:0], 1'b0};
      SH_NIB_OUT: sr_d = {sr_q[27:0], 4'h0};
      SH_NIB_IN:  sr_d = {sr_q[27:0], din};
      default:    sr_d = sr_q;
    endcase
    cnt_d = cnt_q;
    if (op == SH_LOAD || clr) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

  assign sr  = sr_q;
  assign cnt = cnt_q;

endmodule

// File: rtl/psram_ctrl.sv
// QSPI PSRAM master: 0x38 quad write / 0xEB quad read, 1-4 bytes per request.
// Define PSRAM_CTRL_BOUND_CHECK_EN to reject requests crossing the 16 MB top.
module psram_ctrl
  import psram_pkg::*;
#(
  parameter int DUMMY_CYCLES  = 6,
  parameter int CE_GAP_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset,
  psram_ctrl_if.slave bus,
  output logic        sck,
  output logic        ce_n,
  output logic [3:0]  dio_out,
  output logic [3:0]  dio_oe,
  input  logic [3:0]  dio_in
);

  state_e      state_q, state_d;
  logic        phase_q, phase_d;
  logic        wr_q, wr_d;
  logic [2:0]  n_q, n_d;
  logic [31:0] wdata_q, wdata_d;

  sh_op_e      sh_op;
  logic [31:0] sh_load;
  logic [31:0] sr;
  logic [3:0]  cnt;
  logic        tick;
  logic        clr;

  logic        accept;
  logic        on_bus;
  logic        oob;
  logic        err;
  logic [2:0]  req_n;
  logic [3:0]  last_nib;
  logic [5:0]  shamt;

  assign req_n    = norm_bytes(bus.req_bytes);
  assign accept   = state_q == IDLE && bus.req_valid && !reset;
  assign on_bus   = state_q inside {CMD, ADDR, WDATA, DUMMY, RDATA};
  assign last_nib = {n_q, 1'b0} - 4'd1;
  // Short reads land in the low bytes; align byte 0 to the top first.
  assign shamt    = {3'd4 - n_q, 3'b000};

`ifdef PSRAM_CTRL_BOUND_CHECK_EN
  logic err_q, err_d;

  assign oob = ({1'b0, bus.req_addr} + 25'(req_n)) > 25'h100_0000;

  always_comb begin
    err_d = err_q;
    if (accept) err_d = oob;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  assign err = err_q;
`else
  assign oob = 1'b0;
  assign err = 1'b0;
`endif

  assign bus.resp_err   = state_q == RESP && err;
  assign bus.resp_rdata =
    (state_q == RESP && !wr_q && !err) ? bswap(sr << shamt) : '0;

  psram_ctrl_shifter u_shifter (
    .clock    (clock),
    .reset    (reset),
    .op       (sh_op),
    .load_val (sh_load),
    .din      (dio_in),
    .tick     (tick),
    .clr      (clr),
    .sr       (sr),
    .cnt      (cnt)
  );

  always_comb begin
    state_d        = state_q;
    phase_d        = (on_bus || state_q == GAP) ? ~phase_q : 1'b0;
    wr_d           = wr_q;
    n_d            = n_q;
    wdata_d        = wdata_q;
    sh_op          = SH_HOLD;
    sh_load        = '0;
    tick           = 1'b0;
    clr            = 1'b0;
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    sck            = on_bus & phase_q;
    ce_n           = ~on_bus;
    dio_out        = '0;
    dio_oe         = '0;
    unique case (state_q)
      IDLE: begin
        bus.req_ready = ~reset;
        if (accept) begin
          wr_d    = bus.req_write;
          n_d     = req_n;
          wdata_d = bus.req_wdata;
          sh_op   = SH_LOAD;
          sh_load = {bus.req_write ? PSRAM_CMD_QWRITE
                                   : PSRAM_CMD_QREAD,
                     bus.req_addr};
          state_d = oob ? RESP : CMD;
        end
      end
      CMD: begin
        dio_oe  = 4'b0001;
        dio_out = {3'b000, sr[31]};
        if (phase_q) begin
          tick  = 1'b1;
          sh_op = SH_BIT;
          if (cnt == 4'd7) begin
            clr     = 1'b1;
            state_d = ADDR;
          end
        end
      end
      ADDR: begin
        dio_oe  = 4'hF;
        dio_out = sr[31:28];
        if (phase_q) begin
          tick  = 1'b1;
          sh_op = SH_NIB_OUT;
          if (cnt == 4'd5) begin
            if (wr_q) begin
              sh_op   = SH_LOAD;
              sh_load = bswap(wdata_q);
              state_d = WDATA;
            end else begin
              clr     = 1'b1;
              state_d = DUMMY;
            end
          end
        end
      end
      WDATA: begin
        dio_oe  = 4'hF;
        dio_out = sr[31:28];
        if (phase_q) begin
          tick  = 1'b1;
          sh_op = SH_NIB_OUT;
          if (cnt == last_nib) begin
            clr     = 1'b1;
            state_d = RESP;
          end
        end
      end
      DUMMY: begin
        if (phase_q) begin
          tick = 1'b1;
          if (cnt == 4'(DUMMY_CYCLES - 1)) begin
            clr     = 1'b1;
            state_d = RDATA;
          end
        end
      end
      RDATA: begin
        if (phase_q) begin
          tick  = 1'b1;
          sh_op = SH_NIB_IN;
          if (cnt == last_nib) begin
            clr     = 1'b1;
            state_d = RESP;
          end
        end
      end
      RESP: begin
        bus.resp_valid = 1'b1;
        if (bus.resp_ready) begin
          clr     = 1'b1;
          state_d = GAP;
        end
      end
      GAP: begin
        if (phase_q) begin
          tick = 1'b1;
          if (cnt == 4'(CE_GAP_CYCLES - 1)) begin
            clr     = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      phase_q <= 1'b0;
      wr_q    <= 1'b0;
      n_q     <= 3'd4;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      wr_q    <= wr_d;
      n_q     <= n_d;
      wdata_q <= wdata_d;
    end
  end

endmodule

// File: tb/tb_psram_ctrl.sv
// Directed bench for psram_ctrl with a small behavioural QSPI PSRAM model.
module tb_psram_ctrl;

  localparam int DUMMY = 6;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       sck;
  logic       ce_n;
  logic [3:0] dio_out;
  logic [3:0] dio_oe;
  logic [3:0] dio_in = 4'h0;

  psram_ctrl_if bus ();

  psram_ctrl dut (
    .clock   (clock),
    .reset   (reset),
    .bus     (bus),
    .sck     (sck),
    .ce_n    (ce_n),
    .dio_out (dio_out),
    .dio_oe  (dio_oe),
    .dio_in  (dio_in)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Device model: decodes command/address on sck rise, stores writes,
  // drives read nibbles after the dummy cycles.
  logic [7:0]  mem [4096] = '{default: 8'h00};
  logic [7:0]  m_cmd   = '0;
  logic [23:0] m_addr  = '0;
  int          m_rises = 0;
  logic        m_bad   = 1'b0;
  logic [3:0]  m_nibs[$];

  always @(negedge ce_n or posedge sck) begin
    int          j;
    logic [23:0] a;
    logic [7:0]  b;
    if (!sck) begin
      m_cmd   = '0;
      m_addr  = '0;
      m_rises = 0;
      m_bad   = 1'b0;
      m_nibs.delete();
    end else if (!ce_n) begin
      if (m_rises < 8) begin
        m_cmd = {m_cmd[6:0], dio_out[0]};
        if (dio_oe !== 4'h1 || dio_out[3:1] !== 3'b000) m_bad = 1'b1;
      end else if (m_rises < 14) begin
        m_addr = {m_addr[19:0], dio_out};
        if (dio_oe !== 4'hF) m_bad = 1'b1;
      end else if (m_cmd == 8'h38) begin
        j = m_rises - 14;
        if (dio_oe !== 4'hF) m_bad = 1'b1;
        m_nibs.push_back(dio_out);
        if (j % 2 == 1) begin
          a = m_addr + 24'(j / 2);
          mem[a[11:0]] = {m_nibs[j-1], dio_out};
        end
      end else begin
        if (dio_oe !== 4'h0) m_bad = 1'b1;
        if (m_rises >= 14 + DUMMY) begin
          j = m_rises - 14 - DUMMY;
          a = m_addr + 24'(j / 2);
          b = mem[a[11:0]];
          dio_in = (j % 2 == 0) ? b[7:4] : b[3:0];
        end else begin
          dio_in = 4'h0;
        end
      end
      m_rises++;
    end
  end

  int ce_falls = 0;
  always @(negedge ce_n) ce_falls++;

  int rv_cnt   = 0;
  int both_bad = 0;
  always @(negedge clock) begin
    if (bus.resp_valid) rv_cnt++;
    if (bus.resp_valid && bus.req_ready) both_bad++;
  end

  task automatic do_txn(input logic wr, input logic [23:0] addr,
                        input logic [2:0] nb, input logic [31:0] wd,
                        input int hold, output logic [31:0] rd,
                        output logic er, output int lat,
                        output int gap, output logic stable);
    int w;
    w = 0;
    while (!bus.req_ready && w < 100) begin
      @(posedge clock); #1; w++;
    end
    chk("ready_wait", 32'(w < 100), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = addr;
    bus.req_bytes = nb;
    bus.req_wdata = wd;
    @(posedge clock); #1;
    bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.resp_valid && lat < 300) begin
      @(posedge clock); #1; lat++;
    end
    rd     = bus.resp_rdata;
    er     = bus.resp_err;
    stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(posedge clock); #1;
      if (!bus.resp_valid || bus.resp_rdata !== rd ||
          bus.resp_err !== er || bus.req_ready) stable = 1'b0;
    end
    bus.resp_ready = 1'b1;
    @(posedge clock); #1;
    bus.resp_ready = 1'b0;
    gap = 0;
    while (!bus.req_ready && gap < 100) begin
      gap++; @(posedge clock); #1;
    end
  endtask

  typedef struct {
    logic        wr;
    logic [23:0] addr;
    logic [2:0]  nb;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    int          exp_lat;
    int          exp_rises;
  } vec_t;

  vec_t vt [9];

  initial begin
    logic [31:0] rd;
    logic        er;
    logic        st;
    int          lat;
    int          gap;
    int          snap;

    vt[0] = '{1'b1, 24'h000100, 3'd4, 32'h11223344, 32'h0,        45, 22};
    vt[1] = '{1'b0, 24'h000100, 3'd4, 32'h0,        32'h11223344, 57, 28};
    vt[2] = '{1'b0, 24'h000102, 3'd1, 32'h0,        32'h00000022, 45, 22};
    vt[3] = '{1'b1, 24'h000200, 3'd2, 32'hDEADBEEF, 32'h0,        37, 18};
    vt[4] = '{1'b0, 24'h000200, 3'd3, 32'h0,        32'h0000BEEF, 53, 26};
    vt[5] = '{1'b1, 24'h000300, 3'd0, 32'hA5B6C7D8, 32'h0,        45, 22};
    vt[6] = '{1'b0, 24'h000301, 3'd7, 32'h0,        32'h00A5B6C7, 57, 28};
    vt[7] = '{1'b1, 24'h000101, 3'd1, 32'h000000AB, 32'h0,        33, 16};
    vt[8] = '{1'b0, 24'h000100, 3'd2, 32'h0,        32'h0000AB44, 49, 24};

    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_addr   = '0;
    bus.req_bytes  = '0;
    bus.req_wdata  = '0;
    bus.resp_ready = 1'b0;

    #1 reset = 1'b1;
    #2;
    chk("rst_req_ready",  32'(bus.req_ready),  32'd0);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_resp_rdata", bus.resp_rdata,      32'd0);
    chk("rst_resp_err",   32'(bus.resp_err),   32'd0);
    chk("rst_pads", {20'h0, sck, ce_n, 2'b00, dio_out, dio_oe},
        {20'h0, 1'b0, 1'b1, 2'b00, 4'h0, 4'h0});
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    #1;
    chk("post_rst_ready", 32'(bus.req_ready), 32'd1);

    for (int i = 0; i < 9; i++) begin
      do_txn(vt[i].wr, vt[i].addr, vt[i].nb, vt[i].wd, 0,
             rd, er, lat, gap, st);
      chk($sformatf("v%0d_rdata", i), rd, vt[i].exp_rd);
      chk($sformatf("v%0d_err", i), 32'(er), 32'd0);
      chk($sformatf("v%0d_latency", i), lat, vt[i].exp_lat);
      chk($sformatf("v%0d_gap", i), gap, 32'd4);
      chk($sformatf("v%0d_cmd", i), 32'(m_cmd),
          vt[i].wr ? 32'h38 : 32'hEB);
      chk($sformatf("v%0d_addr", i), 32'(m_addr), 32'(vt[i].addr));
      chk($sformatf("v%0d_sck_rises", i), m_rises, vt[i].exp_rises);
      chk($sformatf("v%0d_pad_protocol", i), 32'(m_bad), 32'd0);
      chk($sformatf("v%0d_ce_n_after", i), 32'(ce_n), 32'd1);
      if (i == 0) begin
        logic [31:0] p;
        p = '0;
        for (int k = 0; k < 8; k++)
          p = {p[27:0], (k < m_nibs.size()) ? m_nibs[k] : 4'h0};
        chk("v0_wr_nibbles", p, 32'h44332211);
      end
    end

    // Response back-pressure: hold resp_ready low for 10 clocks.
    do_txn(1'b0, 24'h000100, 3'd4, 32'h0, 10, rd, er, lat, gap, st);
    chk("hold_rdata",  rd,        32'h1122AB44);
    chk("hold_stable", 32'(st),   32'd1);
    chk("hold_gap",    gap,       32'd4);
    chk("hold_lat",    lat,       32'd57);

    // Reset in the middle of the address phase.
    snap = rv_cnt;
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = 24'h000100;
    bus.req_bytes = 3'd4;
    @(posedge clock); #1;
    bus.req_valid = 1'b0;
    repeat (19) begin @(posedge clock); #1; end
    chk("pre_rst_addr_oe", 32'(dio_oe), 32'hF);
    #2 reset = 1'b1;
    #1;
    chk("midrst_ce_n",   32'(ce_n),   32'd1);
    chk("midrst_dio_oe", 32'(dio_oe), 32'd0);
    chk("midrst_sck",    32'(sck),    32'd0);
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    repeat (60) begin @(posedge clock); #1; end
    chk("midrst_no_resp", rv_cnt - snap, 32'd0);
    do_txn(1'b0, 24'h000100, 3'd4, 32'h0, 0, rd, er, lat, gap, st);
    chk("after_rst_rdata", rd,  32'h1122AB44);
    chk("after_rst_lat",   lat, 32'd57);

    // Request crossing the top of the address space.
    snap = ce_falls;
    do_txn(1'b1, 24'hFFFFFE, 3'd4, 32'h01020304, 0, rd, er, lat, gap, st);
`ifdef PSRAM_CTRL_BOUND_CHECK_EN
    chk("oob_err",      32'(er),         32'd1);
    chk("oob_rdata",    rd,              32'd0);
    chk("oob_ce_falls", ce_falls - snap, 32'd0);
    chk("oob_lat",      lat,             32'd1);
    chk("oob_gap",      gap,             32'd4);
`else
    chk("wrap_err",      32'(er),         32'd0);
    chk("wrap_ce_falls", ce_falls - snap, 32'd1);
    chk("wrap_lat",      lat,             32'd45);
    do_txn(1'b0, 24'hFFFFFE, 3'd4, 32'h0, 0, rd, er, lat, gap, st);
    chk("wrap_rdata",    rd,              32'h01020304);
`endif
    // Last byte of the space is in range in both builds.
    do_txn(1'b0, 24'hFFFFFF, 3'd1, 32'h0, 0, rd, er, lat, gap, st);
    chk("top_byte_err", 32'(er), 32'd0);
    chk("top_byte_lat", lat,     32'd45);
`ifdef PSRAM_CTRL_BOUND_CHECK_EN
    chk("top_byte_rdata", rd, 32'h00000000);
`else
    chk("top_byte_rdata", rd, 32'h00000003);
`endif

    chk("valid_ready_overlap", both_bad, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
